// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: datapath width, opcodes and FSM state encodings.
package exe_stage_pkg;

    localparam int DSIZE_DEF = 32;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SLL = 5;
    localparam int OP_SRL = 6;
    localparam int OP_MUL = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Shift-add multiplier datapath; the sequencing (how many steps) is owned by exe_stage.
module exe_mul_iter
    import exe_stage_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             step,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic [DSIZE-1:0] result
);

    logic [DSIZE-1:0] mcand_r;
    logic [DSIZE-1:0] mplier_r;
    logic [DSIZE-1:0] acc_r;

    // Operand load and one shift-add iteration per step; product kept modulo 2^DSIZE.
    always_ff @(posedge clk) begin
        if (clear) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
        end else if (step) begin
            acc_r    <= mplier_r[0] ? (acc_r + mcand_r) : acc_r;
            mcand_r  <= {mcand_r[DSIZE-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[DSIZE-1:1]};
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

    assign result = acc_r;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus an iterative MUL that stalls upstream while it runs.
// Optional operand forwarding from EXE/WB is enabled with the EXE_FWD_EN macro.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int AWIDTH = 5,
    parameter int OPW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OPW-1:0]    op,
    input  logic [DSIZE-1:0]  rdata1,
    input  logic [DSIZE-1:0]  rdata2,
    input  logic [AWIDTH-1:0] waddr_in,
    output logic              stall,
    output logic              out_valid,
    output logic [AWIDTH-1:0] waddr_out,
    output logic [DSIZE-1:0]  aluoutput_out
`ifdef EXE_FWD_EN
    ,
    input  logic [AWIDTH-1:0] rs1_addr,
    input  logic [AWIDTH-1:0] rs2_addr,
    input  logic [AWIDTH-1:0] fwd_waddr,
    input  logic [DSIZE-1:0]  fwd_data
`endif
);

    localparam int SHW = $clog2(DSIZE);
    localparam int CW  = $clog2(DSIZE + 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [CW-1:0]       cnt_r;
    logic [AWIDTH-1:0]   waddr_r;
    logic [DSIZE-1:0]    op_a_s;
    logic [DSIZE-1:0]    op_b_s;
    logic [DSIZE-1:0]    alu_s;
    logic [DSIZE-1:0]    mul_result_s;
    logic                start_s;
    logic                step_s;
    logic                stall_s;
    logic                out_valid_s;
    logic [AWIDTH-1:0]   waddr_s;
    logic [DSIZE-1:0]    result_s;

`ifdef EXE_FWD_EN
    // A nonzero EXE/WB destination matching a source address overrides the register file value.
    assign op_a_s = ((fwd_waddr != '0) && (rs1_addr == fwd_waddr)) ? fwd_data : rdata1;
    assign op_b_s = ((fwd_waddr != '0) && (rs2_addr == fwd_waddr)) ? fwd_data : rdata2;
`else
    assign op_a_s = rdata1;
    assign op_b_s = rdata2;
`endif

    // Single-cycle ALU; shifts use only the low log2(DSIZE) bits of operand B.
    always_comb begin
        alu_s = '0;
        case (op)
            OPW'(OP_ADD): alu_s = op_a_s + op_b_s;
            OPW'(OP_SUB): alu_s = op_a_s - op_b_s;
            OPW'(OP_AND): alu_s = op_a_s & op_b_s;
            OPW'(OP_OR):  alu_s = op_a_s | op_b_s;
            OPW'(OP_XOR): alu_s = op_a_s ^ op_b_s;
            OPW'(OP_SLL): alu_s = op_a_s << op_b_s[SHW-1:0];
            OPW'(OP_SRL): alu_s = op_a_s >> op_b_s[SHW-1:0];
            default:      alu_s = '0;
        endcase
    end

    exe_mul_iter #(
        .DSIZE(DSIZE)
    ) u_mul (
        .clk    (clk),
        .clear  (rst),
        .start  (start_s),
        .step   (step_s),
        .a      (op_a_s),
        .b      (op_b_s),
        .result (mul_result_s)
    );

    // Next-state and output decode; reset overrides everything so outputs read zero while rst=1.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        step_s       = 1'b0;
        stall_s      = 1'b0;
        out_valid_s  = 1'b0;
        waddr_s      = '0;
        result_s     = '0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op == OPW'(OP_MUL)) begin
                        stall_s      = 1'b1;
                        start_s      = 1'b1;
                        state_next_s = ST_BUSY;
                    end else begin
                        out_valid_s = 1'b1;
                        waddr_s     = waddr_in;
                        result_s    = alu_s;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                step_s  = 1'b1;
                if (cnt_r == CW'(DSIZE - 1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                out_valid_s  = 1'b1;
                waddr_s      = waddr_r;
                result_s     = mul_result_s;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (rst) begin
            state_next_s = ST_IDLE;
            start_s      = 1'b0;
            step_s       = 1'b0;
            stall_s      = 1'b0;
            out_valid_s  = 1'b0;
            waddr_s      = '0;
            result_s     = '0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Iteration counter and the destination held across the multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            waddr_r <= '0;
        end else if (start_s) begin
            cnt_r   <= '0;
            waddr_r <= waddr_in;
        end else if (step_s) begin
            cnt_r   <= cnt_r + CW'(1);
            waddr_r <= waddr_r;
        end else begin
            cnt_r   <= cnt_r;
            waddr_r <= waddr_r;
        end
    end

    assign stall         = stall_s;
    assign out_valid     = out_valid_s;
    assign waddr_out     = waddr_s;
    assign aluoutput_out = result_s;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: driver pushes expected results, a negedge monitor pops and compares.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  waddr_in;
    logic        stall;
    logic        out_valid;
    logic [4:0]  waddr_out;
    logic [31:0] aluoutput_out;
`ifdef EXE_FWD_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_data;
`endif

    int total;
    int bad;
    logic [36:0] sb_q[$];
    logic [36:0] exp_e;

    exe_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .op            (op),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .waddr_in      (waddr_in),
        .stall         (stall),
        .out_valid     (out_valid),
        .waddr_out     (waddr_out),
        .aluoutput_out (aluoutput_out)
`ifdef EXE_FWD_EN
        ,
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .fwd_waddr     (fwd_waddr),
        .fwd_data      (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid result must match the oldest expectation; idle cycles must read zero.
    always @(negedge clk) begin
        if (out_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got waddr=%0d data=%h, none expected", waddr_out, aluoutput_out);
            end else begin
                exp_e = sb_q.pop_front();
                if (waddr_out !== exp_e[36:32] || aluoutput_out !== exp_e[31:0]) begin
                    bad++;
                    $display("FAIL result: got waddr=%0d data=%h, want waddr=%0d data=%h",
                             waddr_out, aluoutput_out, exp_e[36:32], exp_e[31:0]);
                end
            end
        end else begin
            total++;
            if (waddr_out !== 5'd0 || aluoutput_out !== 32'd0) begin
                bad++;
                $display("FAIL bubble: got waddr=%0d data=%h, want 0/0", waddr_out, aluoutput_out);
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    // Present one instruction, hold it while stall is high, and check the stall length.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic [31:0] exp_data, input int exp_stall);
        int n;
        n = 0;
        in_valid = 1'b1;
        op       = o;
        rdata1   = a;
        rdata2   = b;
        waddr_in = wa;
        sb_q.push_back({wa, exp_data});
        @(negedge clk);
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != exp_stall) begin
            bad++;
            $display("FAIL stall_len op=%0d: got %0d cycles want %0d", o, n, exp_stall);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'd0;
        rdata1   = 32'd0;
        rdata2   = 32'd0;
        waddr_in = 5'd0;
`ifdef EXE_FWD_EN
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
        fwd_waddr = 5'd0;
        fwd_data  = 32'd0;
`endif
        // Reset state, with an instruction present to prove outputs are forced low.
        in_valid = 1'b1;
        waddr_in = 5'd3;
        rdata1   = 32'd4;
        @(negedge clk);
        check1("reset_stall", stall, 1'b0);
        check1("reset_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'h0000_0001, 0);
        run_op(3'd1, 32'h0000_0005, 32'h0000_0007, 5'd4,  32'hFFFF_FFFE, 0);
        run_op(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5,  32'h00F0_00F0, 0);
        run_op(3'd3, 32'h1234_0000, 32'h0000_5678, 5'd6,  32'h1234_5678, 0);
        run_op(3'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 5'd7,  32'h5555_AAAA, 0);
        run_op(3'd5, 32'h0000_0001, 32'h0000_0021, 5'd8,  32'h0000_0002, 0);
        run_op(3'd6, 32'h8000_0000, 32'h0000_001F, 5'd10, 32'h0000_0001, 0);
        run_op(3'd0, 32'h0000_0002, 32'h0000_0003, 5'd0,  32'h0000_0005, 0);
        @(posedge clk);
        #1;

        run_op(3'd7, 32'd7, 32'd6, 5'd9, 32'd42, 33);
        @(posedge clk);
        #1;
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0001, 33);
        run_op(3'd7, 32'd3, 32'd5, 5'd12, 32'd15, 33);

        // Reset in the tenth BUSY cycle aborts the multiply without a result.
        in_valid = 1'b1;
        op       = 3'd7;
        rdata1   = 32'd9;
        rdata2   = 32'd9;
        waddr_in = 5'd14;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check1("abort_stall", stall, 1'b0);
        check1("abort_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check1("abort_idle_stall", stall, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        run_op(3'd0, 32'd1, 32'd1, 5'd13, 32'd2, 0);

`ifdef EXE_FWD_EN
        rs1_addr  = 5'd4;
        fwd_waddr = 5'd4;
        fwd_data  = 32'd100;
        run_op(3'd0, 32'd1, 32'd5, 5'd2, 32'd105, 0);
        fwd_waddr = 5'd0;
        run_op(3'd0, 32'd1, 32'd5, 5'd2, 32'd6, 0);
`endif

        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_results: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
